// File: rtl/decode_execute_stage_reg.sv
// decode_execute_stage_reg: elastic Decode->Execute pipeline register.
// The main register M drives the outputs. The skid register S absorbs one
// extra beat, so InReady can come straight from a flop.
// Occupancy is held in the validity bits {mv_q, sv_q}: EMPTY, ONE or FULL.
// The optional performance counters are built only when the macro
// DEC_EX_PERF_CNT_EN is defined. Otherwise StallCount and BubbleCount are tied to 0.
// Handshake: a beat transfers on an edge where valid & ready are both high.
// The producer holds valid/payload until it transfers. Flush squashes held
// beats and overrides any same-cycle transfer.
module decode_execute_stage_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Flush,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [DATA_WIDTH-1:0]     ReadData1In,
    input  logic [DATA_WIDTH-1:0]     ReadData2In,
    input  logic [DATA_WIDTH-1:0]     SignExtendIn,
    input  logic [DATA_WIDTH-1:0]     PCAddrIn,
    input  logic [REG_ADDR_WIDTH-1:0] rtIn,
    input  logic [REG_ADDR_WIDTH-1:0] rdIn,
    input  logic                      BranchIn,
    input  logic                      RegDstIn,
    input  logic                      ALUSrcIn,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControlIn,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [DATA_WIDTH-1:0]     ReadData1Out,
    output logic [DATA_WIDTH-1:0]     ReadData2Out,
    output logic [DATA_WIDTH-1:0]     SignExtendOut,
    output logic [DATA_WIDTH-1:0]     PCAddrOut,
    output logic [REG_ADDR_WIDTH-1:0] rtOut,
    output logic [REG_ADDR_WIDTH-1:0] rdOut,
    output logic                      BranchOut,
    output logic                      RegDstOut,
    output logic                      ALUSrcOut,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControlOut,
    output logic [CNT_WIDTH-1:0]      StallCount,
    output logic [CNT_WIDTH-1:0]      BubbleCount
);

    localparam int PW = 4 * DATA_WIDTH + 2 * REG_ADDR_WIDTH + 3 + ALU_CTRL_WIDTH;

    // Occupancy encodings of {mv, sv}. The value 2'b01 is illegal.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic          mv_q, mv_d;
    logic          sv_q, sv_d;
    logic          in_ready_q, in_ready_d;
    logic [PW-1:0] m_q, m_d;
    logic [PW-1:0] s_q, s_d;
    logic [PW-1:0] in_beat;
    logic          accept;
    logic          consume;

    logic          branch_m, regdst_m, alusrc_m;
    logic [ALU_CTRL_WIDTH-1:0] aluctrl_m;

    assign in_beat = {ReadData1In, ReadData2In, SignExtendIn, PCAddrIn,
                      rtIn, rdIn, BranchIn, RegDstIn, ALUSrcIn, ALUControlIn};

    assign accept  = InValid & in_ready_q;
    assign consume = mv_q & OutReady;

    // Next-state and payload steering for the two-entry buffer.
    always_comb begin
        mv_d = mv_q;
        sv_d = sv_q;
        m_d  = m_q;
        s_d  = s_q;
        if (Flush) begin
            mv_d = 1'b0;
            sv_d = 1'b0;
        end else begin
            case ({mv_q, sv_q})
                ST_EMPTY: begin
                    if (accept) begin
                        mv_d = 1'b1;
                        m_d  = in_beat;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        m_d = in_beat;
                    end else if (accept) begin
                        sv_d = 1'b1;
                        s_d  = in_beat;
                    end else if (consume) begin
                        mv_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        sv_d = 1'b0;
                        m_d  = s_q;
                    end
                end
                default: begin
                    // Illegal encoding: recover to EMPTY.
                    mv_d = 1'b0;
                    sv_d = 1'b0;
                end
            endcase
        end
        in_ready_d = ~sv_d;
    end

    // State and payload registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mv_q       <= 1'b0;
            sv_q       <= 1'b0;
            in_ready_q <= 1'b1;
            m_q        <= '0;
            s_q        <= '0;
        end else begin
            mv_q       <= mv_d;
            sv_q       <= sv_d;
            in_ready_q <= in_ready_d;
            m_q        <= m_d;
            s_q        <= s_d;
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = mv_q;

    assign {ReadData1Out, ReadData2Out, SignExtendOut, PCAddrOut,
            rtOut, rdOut, branch_m, regdst_m, alusrc_m, aluctrl_m} = m_q;

    // Controls are gated by validity, so an empty stage presents a NOP.
    assign BranchOut     = branch_m & mv_q;
    assign RegDstOut     = regdst_m & mv_q;
    assign ALUSrcOut     = alusrc_m & mv_q;
    assign ALUControlOut = aluctrl_m & {ALU_CTRL_WIDTH{mv_q}};

`ifdef DEC_EX_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating stall and bubble counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (mv_q && !OutReady && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (!mv_q && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    // Counter registers. They clear only on reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign StallCount  = stall_cnt_q;
    assign BubbleCount = bubble_cnt_q;
`else
    assign StallCount  = '0;
    assign BubbleCount = '0;
`endif

endmodule
